mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Latches the execute-to-memory bus and collects the synchronous data-SRAM read data.
- Performs load byte/halfword extraction and sign/zero extension, then selects the final result from ALU, multiplier or memory.
- Drives the memory-to-writeback bus and forwarding/hazard info to decode, using valid/allowin handshakes.

Parameters:
ES2MS_W, 71, width of es2ms_bus = {pc[31:0], alu_result[31:0], res_from_mem, dest[4:0], gr_we}
MS2WS_W, 70, width of ms2ws_bus = {pc[31:0], final_result[31:0], dest[4:0], gr_we}

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es2ms_valid  in  1  execute stage has an instruction for this stage
ms_allowin  out  1  this stage can accept an instruction this cycle
es2ms_bus  in  ES2MS_W  execute payload, fields as above
es_res_from_mul  in  1  instruction result comes from the multiplier
es_mul_result  in  32  multiplier result, qualified with es2ms_valid
es_ld_op  in  3  load type: 000 ld.w, 001 ld.h, 010 ld.hu, 011 ld.b, 100 ld.bu; others are treated as ld.w
data_sram_rdata  in  32  synchronous SRAM read data, valid the cycle after the request
ws_allowin  in  1  writeback can accept
ms2ws_valid  out  1  this stage presents a valid instruction to writeback
ms2ws_bus  out  MS2WS_W  writeback payload
mem_dest  out  5  destination register for hazard/forward logic; 0 when not writing
mem_rf_we  out  1  ms_valid && gr_we
mem_fwd_data  out  32  final_result, for forwarding to decode

Behaviour:
- Reset: ms_valid=0, rdata_held=0, all payload regs=0.
  - Outputs after reset: ms2ws_valid=0, mem_rf_we=0, mem_dest=0, ms_allowin=1.
  - Reset wins over any same-cycle es2ms_valid; an instruction in flight is dropped.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms2ws_valid = ms_valid & ms_ready_go.
  - When ms_allowin: ms_valid <= es2ms_valid.
  - When es2ms_valid & ms_allowin, latch all bus fields plus res_from_mul, mul_result and ld_op. Otherwise the payload holds.
  - Zero-bubble throughput: one instruction per cycle when ws_allowin=1.
- Read-data hold:
  - The SRAM output can be overwritten while this stage stalls, because execute may issue its next request.
  - On the first cycle an instruction with res_from_mem is valid here (rdata_held=0), capture data_sram_rdata into rdata_buf and set rdata_held.
  - rdata_held clears whenever a new instruction is latched. If that coincides with a capture, the clear wins.
  - ld_raw = rdata_held ? rdata_buf : data_sram_rdata.
- Load extraction, by alu_result[1:0]:
  - ld.b/bu: select byte [8*a+7:8*a].
  - ld.h/hu: select halfword [16*a[1]+15:16*a[1]]; a[0] is ignored (alignment is checked upstream).
  - b and h sign-extend; bu and hu zero-extend; ld.w passes the word through.
- Result select, priority order: res_from_mem ? ld_data : res_from_mul ? mul_result : alu_result.
- Forwarding:
  - mem_dest = (ms_valid & gr_we) ? dest : 0.
  - mem_fwd_data is valid in the same cycle the instruction is here; loads forward with no load-use stall.
- Simultaneous stall and new offer: with ms_valid=1 and ws_allowin=0, es2ms_valid is ignored and the payload and rdata_buf are unchanged.

Test Plan:
- Reset asserted mid-stream while holding a valid load → next cycle ms2ws_valid=0, mem_rf_we=0, mem_dest=0, ms_allowin=1.
- ld.w: alu_result=0x1000, rdata=0xDEADBEEF, dest=5 → ms2ws_bus final_result=0xDEADBEEF, dest=5, gr_we=1, ms2ws_valid=1 the cycle after the handshake.
- Sub-word loads, rdata=0x80F17F02:
  - ld.b addr[1:0]=3 → 0xFFFFFF80.
  - ld.bu addr=3 → 0x00000080.
  - ld.h addr=2 → 0xFFFF80F1.
  - ld.hu addr=0 → 0x00007F02.
- Stall hold: load enters, ws_allowin=0 for 3 cycles, data_sram_rdata changes 0x11111111→0x22222222 after cycle 1 → final_result stays 0x11111111; ms_allowin=0 throughout; the load drains when ws_allowin=1.
- Multiplier path: res_from_mul=1, mul_result=0x00000C35, alu_result=0x5 → final_result=0x00000C35, mem_fwd_data=0x00000C35.
- Back-to-back streaming with ws_allowin=1: three ALU instructions on consecutive cycles → three consecutive ms2ws_valid cycles, no bubbles, with correct pc order.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute payload, holds the
// synchronous SRAM read data across stalls, extracts and extends sub-word
// loads, and selects the final result for writeback and forwarding.
module mem_stage #(
  parameter int ES2MS_W = 71,
  parameter int MS2WS_W = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es2ms_valid,
  output logic               ms_allowin,
  input  logic [ES2MS_W-1:0] es2ms_bus,
  input  logic               es_res_from_mul,
  input  logic [31:0]        es_mul_result,
  input  logic [2:0]         es_ld_op,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allowin,
  output logic               ms2ws_valid,
  output logic [MS2WS_W-1:0] ms2ws_bus,
  output logic [4:0]         mem_dest,
  output logic               mem_rf_we,
  output logic [31:0]        mem_fwd_data
);

  logic        ms_valid;
  logic        ms_ready_go;
  logic        ms_latch;

  logic [31:0] ms_pc;
  logic [31:0] ms_alu_result;
  logic        ms_res_from_mem;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_res_from_mul;
  logic [31:0] ms_mul_result;
  logic [2:0]  ms_ld_op;

  logic [31:0] rdata_buf;
  logic        rdata_held;
  logic        rdata_capture;

  logic [31:0] ld_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go;
  assign ms_latch    = es2ms_valid & ms_allowin;

  // Capture SRAM data on the first cycle a load sits here; later cycles
  // would see whatever execute's next request returned.
  assign rdata_capture = ms_valid & ms_res_from_mem & ~rdata_held;

  // Stage valid bit: advances only when the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es2ms_valid;
    end
  end

  // Payload registers: load on handshake, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_pc           <= '0;
      ms_alu_result   <= '0;
      ms_res_from_mem <= 1'b0;
      ms_dest         <= '0;
      ms_gr_we        <= 1'b0;
      ms_res_from_mul <= 1'b0;
      ms_mul_result   <= '0;
      ms_ld_op        <= '0;
    end else if (ms_latch) begin
      ms_pc           <= es2ms_bus[70:39];
      ms_alu_result   <= es2ms_bus[38:7];
      ms_res_from_mem <= es2ms_bus[6];
      ms_dest         <= es2ms_bus[5:1];
      ms_gr_we        <= es2ms_bus[0];
      ms_res_from_mul <= es_res_from_mul;
      ms_mul_result   <= es_mul_result;
      ms_ld_op        <= es_ld_op;
    end
  end

  // Read-data hold buffer; a newly latched instruction clears the held flag
  // even if a capture happens in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf  <= '0;
      rdata_held <= 1'b0;
    end else begin
      if (rdata_capture) begin
        rdata_buf  <= data_sram_rdata;
        rdata_held <= 1'b1;
      end
      if (ms_latch) begin
        rdata_held <= 1'b0;
      end
    end
  end

  assign ld_raw = rdata_held ? rdata_buf : data_sram_rdata;

  // Byte/halfword lane selection by the low address bits.
  always_comb begin
    ld_byte = ld_raw[7:0];
    case (ms_alu_result[1:0])
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ms_alu_result[1] ? ld_raw[31:16] : ld_raw[15:0];
  end

  // Sign/zero extension by load type; unknown codes behave as ld.w.
  always_comb begin
    ld_data = ld_raw;
    case (ms_ld_op)
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = {16'h0000, ld_half};
      3'b011:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      default: ld_data = ld_raw;
    endcase
  end

  // Final result select: memory over multiplier over ALU.
  always_comb begin
    final_result = ms_alu_result;
    if (ms_res_from_mem) begin
      final_result = ld_data;
    end else if (ms_res_from_mul) begin
      final_result = ms_mul_result;
    end
  end

  assign ms2ws_bus    = {ms_pc, final_result, ms_dest, ms_gr_we};
  assign mem_rf_we    = ms_valid & ms_gr_we;
  assign mem_dest     = (ms_valid & ms_gr_we) ? ms_dest : 5'd0;
  assign mem_fwd_data = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback-side scoreboard.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic [70:0] es2ms_bus;
  logic        es_res_from_mul;
  logic [31:0] es_mul_result;
  logic [2:0]  es_ld_op;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [69:0] ms2ws_bus;
  logic [4:0]  mem_dest;
  logic        mem_rf_we;
  logic [31:0] mem_fwd_data;

  int unsigned tests;
  int unsigned fails;
  logic [69:0] sb[$];

  mem_stage #(.ES2MS_W(71), .MS2WS_W(70)) dut (
    .clk            (clk),
    .reset          (reset),
    .es2ms_valid    (es2ms_valid),
    .ms_allowin     (ms_allowin),
    .es2ms_bus      (es2ms_bus),
    .es_res_from_mul(es_res_from_mul),
    .es_mul_result  (es_mul_result),
    .es_ld_op       (es_ld_op),
    .data_sram_rdata(data_sram_rdata),
    .ws_allowin     (ws_allowin),
    .ms2ws_valid    (ms2ws_valid),
    .ms2ws_bus      (ms2ws_bus),
    .mem_dest       (mem_dest),
    .mem_rf_we      (mem_rf_we),
    .mem_fwd_data   (mem_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one instruction from execute.
  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic rfm,
                      input logic [4:0] dest, input logic we, input logic mul,
                      input logic [31:0] mulres, input logic [2:0] ldop);
    es2ms_valid     = 1'b1;
    es2ms_bus       = {pc, alu, rfm, dest, we};
    es_res_from_mul = mul;
    es_mul_result   = mulres;
    es_ld_op        = ldop;
  endtask

  task automatic idle();
    es2ms_valid     = 1'b0;
    es2ms_bus       = '0;
    es_res_from_mul = 1'b0;
    es_mul_result   = '0;
    es_ld_op        = '0;
  endtask

  // One clock: check any writeback transfer at negedge, then move to 1ns
  // after the next rising edge where new inputs are driven.
  task automatic cycle();
    logic [69:0] exp;
    @(negedge clk);
    if (ms2ws_valid && ws_allowin) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_wb observed=%h expected=none", ms2ws_bus);
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("wb_bus", ms2ws_bus, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    ws_allowin = 1'b1;
    data_sram_rdata = '0;
    idle();
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_valid", ms2ws_valid, 0);
    chk("rst_rf_we", mem_rf_we, 0);
    chk("rst_dest", mem_dest, 0);
    chk("rst_allowin", ms_allowin, 1);

    // ld.w
    send(32'h100, 32'h1000, 1'b1, 5'd5, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h100, 32'hDEADBEEF, 5'd5, 1'b1});
    cycle();
    idle();
    data_sram_rdata = 32'hDEADBEEF;
    #1;
    chk("ldw_valid", ms2ws_valid, 1);
    chk("ldw_dest", mem_dest, 5);
    chk("ldw_rf_we", mem_rf_we, 1);
    chk("ldw_fwd", mem_fwd_data, 32'hDEADBEEF);
    cycle();

    // Sub-word loads streamed against a fixed read word
    data_sram_rdata = 32'h80F17F02;
    send(32'h200, 32'h2003, 1'b1, 5'd1, 1'b1, 1'b0, 32'h0, 3'b011);
    sb.push_back({32'h200, 32'hFFFFFF80, 5'd1, 1'b1});
    cycle();
    send(32'h204, 32'h2003, 1'b1, 5'd2, 1'b1, 1'b0, 32'h0, 3'b100);
    sb.push_back({32'h204, 32'h00000080, 5'd2, 1'b1});
    cycle();
    send(32'h208, 32'h2002, 1'b1, 5'd3, 1'b1, 1'b0, 32'h0, 3'b001);
    sb.push_back({32'h208, 32'hFFFF80F1, 5'd3, 1'b1});
    cycle();
    send(32'h20C, 32'h2000, 1'b1, 5'd4, 1'b1, 1'b0, 32'h0, 3'b010);
    sb.push_back({32'h20C, 32'h00007F02, 5'd4, 1'b1});
    cycle();
    send(32'h210, 32'h2001, 1'b1, 5'd6, 1'b1, 1'b0, 32'h0, 3'b011);
    sb.push_back({32'h210, 32'h0000007F, 5'd6, 1'b1});
    cycle();
    send(32'h214, 32'h2003, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 3'b001);
    sb.push_back({32'h214, 32'hFFFF80F1, 5'd7, 1'b1});
    cycle();
    send(32'h218, 32'h2000, 1'b1, 5'd8, 1'b1, 1'b0, 32'h0, 3'b101);
    sb.push_back({32'h218, 32'h80F17F02, 5'd8, 1'b1});
    cycle();
    idle();
    cycle();

    // Stall with changing SRAM output and an ignored new offer
    send(32'h300, 32'h3000, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h300, 32'h11111111, 5'd7, 1'b1});
    cycle();
    idle();
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h11111111;
    #1;
    chk("stall1_allowin", ms_allowin, 0);
    chk("stall1_fwd", mem_fwd_data, 32'h11111111);
    cycle();
    data_sram_rdata = 32'h22222222;
    send(32'h400, 32'h4000, 1'b0, 5'd9, 1'b1, 1'b0, 32'h0, 3'b000);
    #1;
    chk("stall2_allowin", ms_allowin, 0);
    chk("stall2_fwd", mem_fwd_data, 32'h11111111);
    chk("stall2_valid", ms2ws_valid, 1);
    cycle();
    #1;
    chk("stall3_allowin", ms_allowin, 0);
    chk("stall3_fwd", mem_fwd_data, 32'h11111111);
    cycle();
    idle();
    ws_allowin = 1'b1;
    #1;
    chk("drain_fwd", mem_fwd_data, 32'h11111111);
    cycle();
    chk("drain_empty", ms2ws_valid, 0);

    // Multiplier path, memory priority over multiplier, non-writing instr
    send(32'h500, 32'h5, 1'b0, 5'd9, 1'b1, 1'b1, 32'h00000C35, 3'b000);
    sb.push_back({32'h500, 32'h00000C35, 5'd9, 1'b1});
    cycle();
    idle();
    data_sram_rdata = 32'hA5A5A5A5;
    #1;
    chk("mul_fwd", mem_fwd_data, 32'h00000C35);
    chk("mul_dest", mem_dest, 9);
    send(32'h504, 32'h6000, 1'b1, 5'd10, 1'b1, 1'b1, 32'h12345678, 3'b000);
    sb.push_back({32'h504, 32'h5A5A0F0F, 5'd10, 1'b1});
    cycle();
    send(32'h508, 32'h77, 1'b0, 5'd3, 1'b0, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h508, 32'h00000077, 5'd3, 1'b0});
    data_sram_rdata = 32'h5A5A0F0F;
    #1;
    chk("memprio_fwd", mem_fwd_data, 32'h5A5A0F0F);
    cycle();
    idle();
    #1;
    chk("nowe_dest", mem_dest, 0);
    chk("nowe_rf_we", mem_rf_we, 0);
    cycle();

    // Back-to-back ALU stream
    send(32'h600, 32'hA, 1'b0, 5'd11, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h600, 32'h0000000A, 5'd11, 1'b1});
    cycle();
    send(32'h604, 32'hB, 1'b0, 5'd12, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h604, 32'h0000000B, 5'd12, 1'b1});
    #1;
    chk("stream1_valid", ms2ws_valid, 1);
    cycle();
    send(32'h608, 32'hC, 1'b0, 5'd13, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h608, 32'h0000000C, 5'd13, 1'b1});
    #1;
    chk("stream2_valid", ms2ws_valid, 1);
    chk("stream2_allowin", ms_allowin, 1);
    cycle();
    idle();
    #1;
    chk("stream3_valid", ms2ws_valid, 1);
    cycle();
    chk("stream_end", ms2ws_valid, 0);

    // Reset while holding a stalled load, with a same-cycle offer
    send(32'h700, 32'h7000, 1'b1, 5'd14, 1'b1, 1'b0, 32'h0, 3'b000);
    sb.push_back({32'h700, 32'h33333333, 5'd14, 1'b1});
    cycle();
    idle();
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h33333333;
    cycle();
    reset = 1'b1;
    send(32'h800, 32'h8000, 1'b1, 5'd15, 1'b1, 1'b0, 32'h0, 3'b000);
    cycle();
    sb.delete();
    reset = 1'b0;
    idle();
    #1;
    chk("midrst_valid", ms2ws_valid, 0);
    chk("midrst_rf_we", mem_rf_we, 0);
    chk("midrst_dest", mem_dest, 0);
    chk("midrst_allowin", ms_allowin, 1);
    ws_allowin = 1'b1;
    cycle();
    cycle();

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
